// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: FSM state encodings and protocol constants shared by the I2C slave blocks.
package i2c_slave_pkg;
  typedef enum logic [3:0] {
    IDLE, GET_REG, LOOKUP, WRITE_DATA, WRITE_ACK,
    READ_WAIT, READ_FETCH, READ_SEND, ERROR
  } state_t;
  localparam logic I2C_ACK = 1'b1;
  localparam logic I2C_NACK = 1'b0;
  localparam logic [7:0] READ_FILL = 8'hFF;
endpackage

// File: rtl/i2c_slave_mem_ctrl.sv
// i2c_slave_mem_ctrl: turns I2C byte events into register-select, write and read cycles on the slave memory.
module i2c_slave_mem_ctrl
  import i2c_slave_pkg::*;
#(
  parameter int ADDRESSLENGTH = 8,
  parameter int NBYTES = 2,
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     BusStart,
  input  logic                     BusStop,
  input  logic                     Selected,
  input  logic                     ReadNotWrite,
  input  logic                     RxValid,
  input  logic [7:0]               RxByte,
  input  logic                     TxReq,
  output logic [7:0]               TxByte,
  output logic                     TxValid,
  output logic                     Ack,
  output logic                     AckValid,
  output logic                     MemEnable,
  output logic                     MemMode,
  output logic                     MemRorW,
  output logic [ADDRESSLENGTH-1:0] MemDirection,
  output logic [7:0]               MemInput,
  input  logic [7:0]               MemOutput,
  input  logic                     MemFound,
  output logic [BW-1:0]            ByteIndex,
  output logic                     Busy,
  output logic                     ErrorFlag
);
  state_t state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d, mem_in_q, mem_in_d;
  logic tx_valid_q, tx_valid_d, ack_q, ack_d, ack_valid_q, ack_valid_d;
  logic mem_en_q, mem_en_d, mem_mode_q, mem_mode_d, mem_rorw_q, mem_rorw_d;
  logic err_q, err_d;
  logic [ADDRESSLENGTH-1:0] dir_q, dir_d;
  logic [BW-1:0] idx_q, idx_d, idx_inc;
  assign idx_inc = (idx_q == BW'(NBYTES - 1)) ? '0 : idx_q + BW'(1);
  always_ff @(posedge Clk)
    if (Reset) begin
      state_q     <= IDLE;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      ack_q       <= 1'b0;
      ack_valid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_mode_q  <= 1'b0;
      mem_rorw_q  <= 1'b0;
      dir_q       <= '0;
      mem_in_q    <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      ack_q       <= ack_d;
      ack_valid_q <= ack_valid_d;
      mem_en_q    <= mem_en_d;
      mem_mode_q  <= mem_mode_d;
      mem_rorw_q  <= mem_rorw_d;
      dir_q       <= dir_d;
      mem_in_q    <= mem_in_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
    end
  // Pulses default low every cycle, so MemEnable can never stay high two cycles in a row.
  always_comb begin
    state_d     = state_q;
    tx_byte_d   = tx_byte_q;
    tx_valid_d  = 1'b0;
    ack_d       = ack_q;
    ack_valid_d = 1'b0;
    mem_en_d    = 1'b0;
    mem_mode_d  = mem_mode_q;
    mem_rorw_d  = mem_rorw_q;
    dir_d       = dir_q;
    mem_in_d    = mem_in_q;
    idx_d       = idx_q;
    err_d       = err_q;
    if (BusStop || BusStart) begin
      state_d = IDLE;
    end else if (Selected) begin
      state_d = ReadNotWrite ? READ_WAIT : GET_REG;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        GET_REG: if (RxValid) begin
          dir_d   = ADDRESSLENGTH'(RxByte);
          idx_d   = '0;
          state_d = LOOKUP;
        end
        LOOKUP: begin
          ack_valid_d = 1'b1;
          ack_d       = MemFound ? I2C_ACK : I2C_NACK;
          err_d       = err_q | ~MemFound;
          state_d     = MemFound ? WRITE_DATA : ERROR;
        end
        WRITE_DATA: if (RxValid) begin
          mem_in_d   = RxByte;
          mem_mode_d = 1'b1;
          mem_rorw_d = 1'b1;
          mem_en_d   = 1'b1;
          state_d    = WRITE_ACK;
        end
        WRITE_ACK: begin
          ack_valid_d = 1'b1;
          ack_d       = I2C_ACK;
          idx_d       = idx_inc;
          state_d     = WRITE_DATA;
        end
        READ_WAIT: if (TxReq) begin
          mem_mode_d = MemFound ? 1'b1 : mem_mode_q;
          mem_rorw_d = MemFound ? 1'b0 : mem_rorw_q;
          mem_en_d   = MemFound;
          tx_byte_d  = MemFound ? tx_byte_q : READ_FILL;
          tx_valid_d = ~MemFound;
          err_d      = err_q | ~MemFound;
          state_d    = MemFound ? READ_FETCH : ERROR;
        end
        READ_FETCH: state_d = READ_SEND;
        READ_SEND: begin
          tx_byte_d  = MemOutput;
          tx_valid_d = 1'b1;
          idx_d      = idx_inc;
          state_d    = READ_WAIT;
        end
        ERROR: begin
          ack_valid_d = RxValid;
          ack_d       = RxValid ? I2C_NACK : ack_q;
          tx_valid_d  = TxReq;
          tx_byte_d   = TxReq ? READ_FILL : tx_byte_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign TxByte       = tx_byte_q;
  assign TxValid      = tx_valid_q;
  assign Ack          = ack_q;
  assign AckValid     = ack_valid_q;
  assign MemEnable    = mem_en_q;
  assign MemMode      = mem_mode_q;
  assign MemRorW      = mem_rorw_q;
  assign MemDirection = dir_q;
  assign MemInput     = mem_in_q;
  assign ByteIndex    = idx_q;
  assign Busy         = state_q != IDLE;
  assign ErrorFlag    = err_q;
endmodule

// File: tb/tb_i2c_slave_mem_ctrl.sv
// tb_i2c_slave_mem_ctrl: vector-table and scoreboard bench with a behavioural two-byte register memory.
module tb_i2c_slave_mem_ctrl;
  logic clk, rst, bus_start, bus_stop, selected, rnw, rx_valid, tx_req;
  logic [7:0] rx_byte, tx_byte, mem_in, mem_dir, mem_out;
  logic tx_valid, ack, ack_valid, mem_en, mem_mode, mem_rorw, mem_found, busy, err;
  logic [0:0] byte_index;
  i2c_slave_mem_ctrl #(.ADDRESSLENGTH(8), .NBYTES(2)) dut (
    .Clk(clk), .Reset(rst), .BusStart(bus_start), .BusStop(bus_stop),
    .Selected(selected), .ReadNotWrite(rnw), .RxValid(rx_valid), .RxByte(rx_byte),
    .TxReq(tx_req), .TxByte(tx_byte), .TxValid(tx_valid), .Ack(ack), .AckValid(ack_valid),
    .MemEnable(mem_en), .MemMode(mem_mode), .MemRorW(mem_rorw), .MemDirection(mem_dir),
    .MemInput(mem_in), .MemOutput(mem_out), .MemFound(mem_found), .ByteIndex(byte_index),
    .Busy(busy), .ErrorFlag(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic present(input logic [7:0] a);
    return a == 8'h05 || a == 8'h10 || a == 8'h22;
  endfunction
  logic [7:0] mem [256][2];
  logic mcnt, en_q, new_reg;
  assign mem_found = present(mem_dir);
  // Memory acts on the rising edge of MemEnable and keeps its own byte counter.
  always @(posedge clk) begin
    en_q <= mem_en;
    if (rst || new_reg) mcnt <= 1'b0;
    else if (mem_en && !en_q) begin
      if (mem_rorw) mem[mem_dir][mcnt] <= mem_in;
      else mem_out <= mem[mem_dir][mcnt];
      mcnt <= ~mcnt;
    end
  end
  typedef struct { int cyc; logic rorw; logic [7:0] dir; logic [7:0] b; } exp_t;
  typedef struct { logic [7:0] addr; logic [7:0] d0; logic [7:0] d1; logic found; } vec_t;
  exp_t ackq[$], txq[$], memq[$];
  int cyc = 0, checks = 0, errors = 0;
  logic prev_en = 1'b0;
  logic [7:0] cur = 8'h00;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic mon();
    exp_t e;
    if (ack_valid === 1'b1) begin
      chk("ack_expected", ackq.size() != 0, 1);
      if (ackq.size() != 0) begin
        e = ackq.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_value", ack, e.b);
      end
    end
    if (tx_valid === 1'b1) begin
      chk("tx_expected", txq.size() != 0, 1);
      if (txq.size() != 0) begin
        e = txq.pop_front();
        chk("tx_cycle", cyc, e.cyc);
        chk("tx_byte", tx_byte, e.b);
      end
    end
    if (mem_en === 1'b1) begin
      chk("mem_expected", memq.size() != 0, 1);
      chk("mem_gap", prev_en, 0);
      if (memq.size() != 0) begin
        e = memq.pop_front();
        chk("mem_cycle", cyc, e.cyc);
        chk("mem_mode", mem_mode, 1);
        chk("mem_rorw", mem_rorw, e.rorw);
        chk("mem_dir", mem_dir, e.dir);
        if (e.rorw) chk("mem_data", mem_in, e.b);
      end
    end
    prev_en = (mem_en === 1'b1);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      mon();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask
  task automatic sel(input logic r);
    selected = 1'b1; rnw = r; tick(1);
    selected = 1'b0; tick(4);
  endtask
  task automatic restart();
    bus_start = 1'b1; tick(1);
    bus_start = 1'b0; tick(4);
  endtask
  task automatic send_reg(input logic [7:0] a, input logic f);
    cur = a;
    ackq.push_back('{cyc + 2, 1'b0, 8'h00, {7'd0, f}});
    rx_valid = 1'b1; rx_byte = a; new_reg = 1'b1; tick(1);
    rx_valid = 1'b0; new_reg = 1'b0; tick(4);
  endtask
  task automatic send_data(input logic [7:0] d, input logic f);
    if (f) begin
      memq.push_back('{cyc + 1, 1'b1, cur, d});
      ackq.push_back('{cyc + 2, 1'b0, 8'h00, 8'h01});
    end else ackq.push_back('{cyc + 1, 1'b0, 8'h00, 8'h00});
    rx_valid = 1'b1; rx_byte = d; tick(1);
    rx_valid = 1'b0; tick(4);
  endtask
  task automatic rd(input logic [7:0] e, input logic f);
    if (f) begin
      memq.push_back('{cyc + 1, 1'b0, cur, 8'h00});
      txq.push_back('{cyc + 3, 1'b0, 8'h00, e});
    end else txq.push_back('{cyc + 1, 1'b0, 8'h00, 8'hFF});
    tx_req = 1'b1; tick(1);
    tx_req = 1'b0; tick(4);
  endtask
  task automatic chk_reset();
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_ack_valid", ack_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_mode", mem_mode, 0);
    chk("rst_mem_rorw", mem_rorw, 0);
    chk("rst_mem_dir", mem_dir, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_byte_index", byte_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", err, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    vec_t tbl[4];
    tbl[0] = '{8'h05, 8'hAA, 8'hBB, 1'b1};
    tbl[1] = '{8'h10, 8'h3C, 8'hC3, 1'b1};
    tbl[2] = '{8'h7E, 8'h11, 8'h22, 1'b0};
    tbl[3] = '{8'h22, 8'h00, 8'hFF, 1'b1};
    rst = 1'b1; bus_start = 1'b0; bus_stop = 1'b0; selected = 1'b0; rnw = 1'b0;
    rx_valid = 1'b0; rx_byte = 8'h00; tx_req = 1'b0; new_reg = 1'b0;
    tick(2);
    rst = 1'b0;
    chk_reset();
    tick(1);
    sel(1'b1);
    rd(8'hFF, 1'b0);
    chk("noreg_error_set", err, 1);
    sel(1'b1);
    chk("noreg_error_cleared", err, 0);
    restart();
    sel(1'b0);
    send_reg(8'h05, 1'b1);
    send_data(8'h12, 1'b1);
    chk("write_byte_index", byte_index, 1);
    restart();
    foreach (tbl[i]) begin
      sel(1'b0);
      send_reg(tbl[i].addr, tbl[i].found);
      send_data(tbl[i].d0, tbl[i].found);
      send_data(tbl[i].d1, tbl[i].found);
      chk("vec_write_error", err, !tbl[i].found);
      chk("vec_write_index", byte_index, 0);
      restart();
      sel(1'b1);
      chk("vec_sel_error", err, 0);
      rd(tbl[i].found ? tbl[i].d0 : 8'hFF, tbl[i].found);
      rd(tbl[i].found ? tbl[i].d1 : 8'hFF, tbl[i].found);
      rd(tbl[i].found ? tbl[i].d0 : 8'hFF, tbl[i].found);
      chk("vec_read_index", byte_index, tbl[i].found ? 1 : 0);
      chk("vec_read_error", err, !tbl[i].found);
      restart();
    end
    sel(1'b0);
    send_reg(8'h05, 1'b1);
    bus_stop = 1'b1; rx_valid = 1'b1; rx_byte = 8'h55; tick(1);
    bus_stop = 1'b0; rx_valid = 1'b0;
    chk("stop_busy", busy, 0);
    tick(4);
    sel(1'b1);
    memq.push_back('{cyc + 1, 1'b0, cur, 8'h00});
    tx_req = 1'b1; tick(1);
    tx_req = 1'b0; rst = 1'b1; tick(1);
    rst = 1'b0;
    chk_reset();
    tick(5);
    chk("ackq_empty", ackq.size(), 0);
    chk("txq_empty", txq.size(), 0);
    chk("memq_empty", memq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
